// File: rtl/mac_pkg.sv
// Shared types and constants for the 16-bit MAC accumulate controller.
package mac_pkg;
  localparam int ACC_W      = 32;
  localparam int DATA_W_DEF = 16;
  localparam int LEN_W_DEF  = 8;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, HOLD} mac_state_t;
endpackage

// File: rtl/Brent_kung_32bitt.sv
// 32-bit Brent-Kung parallel-prefix adder: sum = a + b + cin, with carry-out.
module Brent_kung_32bitt
  import mac_pkg::*;
(
  input  logic [ACC_W-1:0] a,
  input  logic [ACC_W-1:0] b,
  input  logic             cin,
  output logic [ACC_W-1:0] sum,
  output logic             cout
);

  always_comb begin
    logic [ACC_W-1:0] g;
    logic [ACC_W-1:0] p;
    logic [ACC_W-1:0] hp;
    logic [ACC_W-1:0] carry;
    logic [4:0]       hi;
    logic [4:0]       lo;
    hp = a ^ b;
    g  = a & b;
    p  = hp;
    hi = '0;
    lo = '0;
    // Up-sweep builds group terms at positions 2^(l+1)k-1; down-sweep fills the rest.
    for (int l = 0; l < 5; l++) begin
      for (int i = 0; i < ACC_W; i++) begin
        if (((i + 1) % (2 << l)) == 0) begin
          hi = 5'(i);
          lo = 5'(i - (1 << l));
          g[hi] = g[hi] | (p[hi] & g[lo]);
          p[hi] = p[hi] & p[lo];
        end
      end
    end
    for (int l = 3; l >= 0; l--) begin
      for (int i = 0; i < ACC_W; i++) begin
        if ((i >= (2 << l)) && (((i + 1) % (2 << l)) == (1 << l))) begin
          hi = 5'(i);
          lo = 5'(i - (1 << l));
          g[hi] = g[hi] | (p[hi] & g[lo]);
          p[hi] = p[hi] & p[lo];
        end
      end
    end
    carry = {g[ACC_W-2:0] | (p[ACC_W-2:0] & {(ACC_W-1){cin}}), cin};
    sum   = hp ^ carry;
    cout  = g[ACC_W-1] | (p[ACC_W-1] & cin);
  end

endmodule

// File: rtl/mac_accum_ctrl.sv
// Sequences one multiply-accumulate job: streams cfg_len operand pairs in,
// registers each product, accumulates it, and holds the sum until consumed.
module mac_accum_ctrl
  import mac_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [LEN_W-1:0]  cfg_len,
  output logic              busy,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_acc,
  output logic              out_ovf
);

  mac_state_t       state, next_state;
  logic [LEN_W-1:0] len, count;
  logic [ACC_W-1:0] prod_p1, acc_p2, sum;
  logic             vld_p1, ovf_p2, cout, take, launch;

  assign take   = in_valid & in_ready;
  assign launch = (state == IDLE) & start;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = (cfg_len == '0) ? HOLD : RUN;
      RUN:     if (take && ((count + 1'b1) == len)) next_state = DRAIN;
      DRAIN:   next_state = HOLD;
      HOLD:    if (out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != IDLE);
    in_ready  = (state == RUN);
    out_valid = (state == HOLD);
  end

  // Stage p1: product register, loaded only on an operand handshake.
  always_ff @(posedge clk) begin
    if (take) prod_p1 <= ACC_W'(in_a) * ACC_W'(in_b);
  end

  // Stage p2: accumulate; the final product lands during the single DRAIN cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      len    <= '0;
      count  <= '0;
      vld_p1 <= 1'b0;
      acc_p2 <= '0;
      ovf_p2 <= 1'b0;
    end else begin
      vld_p1 <= take;
      if (take) count <= count + 1'b1;
      if (launch) begin
        len    <= cfg_len;
        count  <= '0;
        acc_p2 <= '0;
        ovf_p2 <= 1'b0;
      end else if (vld_p1) begin
        acc_p2 <= sum;
        ovf_p2 <= ovf_p2 | cout;
      end
    end
  end

  Brent_kung_32bitt u_adder (
    .a    (acc_p2),
    .b    (prod_p1),
    .cin  (1'b0),
    .sum  (sum),
    .cout (cout)
  );

  assign out_acc = acc_p2;
  assign out_ovf = ovf_p2;

endmodule
